// File: rtl/fsm_dfi_mb_if.sv
// Arbiter command channel and DFI command pins of the multi-bank DFI command FSM.
// The master modport is the arbiter/PHY side, the slave modport is the FSM.
interface fsm_dfi_mb_if #(
  parameter int ADDR_W = 14,
  parameter int BANK_W = 3
);
  logic              cmd_valid;
  logic [2:0]        cmd_type;
  logic [31:0]       cmd_addr;
  logic              fsm_ready;
  logic              cmd_done;
  logic              row_hit;
  logic              dfi_cs_n;
  logic              dfi_ras_n;
  logic              dfi_cas_n;
  logic              dfi_we_n;
  logic              dfi_cke;
  logic [ADDR_W-1:0] dfi_addr;
  logic [BANK_W-1:0] dfi_bank;

  modport master (
    output cmd_valid, cmd_type, cmd_addr,
    input  fsm_ready, cmd_done, row_hit,
    input  dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_cke, dfi_addr, dfi_bank
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_addr,
    output fsm_ready, cmd_done, row_hit,
    output dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_cke, dfi_addr, dfi_bank
  );
endinterface

// File: rtl/fsm_dfi_mb.sv
// Multi-bank open-page DFI command FSM: tracks the open row of every bank and
// issues ACT, PRE+ACT, RD/WR or PREA+REF with fixed command spacing.
module fsm_dfi_mb #(
  parameter int ADDR_W = 14,
  parameter int BANK_W = 3,
  parameter int COL_W  = 10,
  parameter int tRCD   = 4,
  parameter int CL     = 4,
  parameter int tRP    = 4,
  parameter int tRFC   = 8
) (
  input logic         clk,
  input logic         rst,
  fsm_dfi_mb_if.slave bus
);
  localparam int NBANK = 2 ** BANK_W;

  localparam logic [2:0] CMD_NOP     = 3'd0;
  localparam logic [2:0] CMD_READ    = 3'd1;
  localparam logic [2:0] CMD_WRITE   = 3'd2;
  localparam logic [2:0] CMD_SCRUB   = 3'd3;
  localparam logic [2:0] CMD_REFRESH = 3'd4;

  // A wait state lasts T-1 cycles, so the counter is loaded with T-2 and exits at 0.
  localparam logic [7:0] LD_RP  = 8'(tRP - 2);
  localparam logic [7:0] LD_RCD = 8'(tRCD - 2);
  localparam logic [7:0] LD_CL  = 8'(CL - 2);
  localparam logic [7:0] LD_RFC = 8'(tRFC - 2);
  localparam logic [ADDR_W-1:0] ADDR_A10 = ADDR_W'(11'h400);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_RDWR,
    S_WAIT_CL, S_PREA, S_WAIT_RPA, S_REF, S_WAIT_RFC
  } state_t;

  state_t            state_r, state_s;
  logic [7:0]        timer_r, timer_s;
  logic [NBANK-1:0]  open_r;
  logic [ADDR_W-1:0] open_row_r [NBANK];
  logic [2:0]        type_r;
  logic [BANK_W-1:0] bank_r;
  logic [ADDR_W-1:0] row_r;
  logic [COL_W-1:0]  col_r;
  logic              hit_r, done_r, row_hit_r;
  logic              accept_s, rw_s, ref_s, hit_s, done_s;
  logic [COL_W-1:0]  col_s;
  logic [BANK_W-1:0] bank_s;
  logic [ADDR_W-1:0] row_s;
  logic              addr_unused_s;
  logic              ras_n_s, cas_n_s, we_n_s;
  logic [ADDR_W-1:0] addr_s;
  logic [BANK_W-1:0] dbank_s;

  assign col_s         = bus.cmd_addr[COL_W-1:0];
  assign bank_s        = bus.cmd_addr[COL_W +: BANK_W];
  assign row_s         = bus.cmd_addr[COL_W+BANK_W +: ADDR_W];
  assign addr_unused_s = ^bus.cmd_addr;
  assign accept_s      = bus.cmd_valid & (state_r == S_IDLE);
  assign hit_s         = rw_s & open_r[bank_s] & (open_row_r[bank_s] == row_s);

  // Command type classification; NOP and undefined codes are neither.
  always_comb begin
    rw_s  = 1'b0;
    ref_s = 1'b0;
    case (bus.cmd_type)
      CMD_NOP:                        rw_s  = 1'b0;
      CMD_READ, CMD_WRITE, CMD_SCRUB: rw_s  = 1'b1;
      CMD_REFRESH:                    ref_s = 1'b1;
      default:                        rw_s  = 1'b0;
    endcase
  end

  // Next-state, wait-counter and completion decode.
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    done_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (accept_s && rw_s) begin
          if (hit_s)               state_s = S_RDWR;
          else if (open_r[bank_s]) state_s = S_PRE;
          else                     state_s = S_ACT;
        end else if (accept_s && ref_s) begin
          state_s = (|open_r) ? S_PREA : S_REF;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_PRE:  begin state_s = S_WAIT_RP;  timer_s = LD_RP;  end
      S_ACT:  begin state_s = S_WAIT_RCD; timer_s = LD_RCD; end
      S_RDWR: begin state_s = S_WAIT_CL;  timer_s = LD_CL;  end
      S_PREA: begin state_s = S_WAIT_RPA; timer_s = LD_RP;  end
      S_REF:  begin state_s = S_WAIT_RFC; timer_s = LD_RFC; end
      S_WAIT_RP, S_WAIT_RCD, S_WAIT_CL, S_WAIT_RPA, S_WAIT_RFC: begin
        if (timer_r != 8'd0) begin
          timer_s = timer_r - 8'd1;
        end else begin
          case (state_r)
            S_WAIT_RP:  state_s = S_ACT;
            S_WAIT_RCD: state_s = S_RDWR;
            S_WAIT_RPA: state_s = S_REF;
            default: begin
              state_s = S_IDLE;
              done_s  = 1'b1;
            end
          endcase
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State, timer, bank-open flags and completion flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      timer_r   <= 8'd0;
      open_r    <= '0;
      done_r    <= 1'b0;
      row_hit_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      timer_r   <= timer_s;
      done_r    <= done_s;
      row_hit_r <= done_s & hit_r;
      case (state_r)
        S_ACT:   open_r[bank_r] <= 1'b1;
        S_PRE:   open_r[bank_r] <= 1'b0;
        S_PREA:  open_r         <= '0;
        default: open_r         <= open_r;
      endcase
    end
  end

  // Latched command fields and per-bank open rows.
  always_ff @(posedge clk) begin
    if (rst) begin
      type_r <= 3'd0;
      bank_r <= '0;
      row_r  <= '0;
      col_r  <= '0;
      hit_r  <= 1'b0;
      for (int i = 0; i < NBANK; i++) open_row_r[i] <= '0;
    end else begin
      if (accept_s) begin
        type_r <= bus.cmd_type;
        bank_r <= bank_s;
        row_r  <= row_s;
        col_r  <= col_s;
        hit_r  <= hit_s;
      end
      if (state_r == S_ACT) open_row_r[bank_r] <= row_r;
    end
  end

  // DFI pin encoding; every command state lasts exactly one cycle.
  always_comb begin
    ras_n_s = 1'b1;
    cas_n_s = 1'b1;
    we_n_s  = 1'b1;
    addr_s  = '0;
    dbank_s = '0;
    case (state_r)
      S_ACT: begin
        ras_n_s = 1'b0;
        addr_s  = row_r;
        dbank_s = bank_r;
      end
      S_RDWR: begin
        cas_n_s = 1'b0;
        we_n_s  = (type_r == CMD_WRITE) ? 1'b0 : 1'b1;
        addr_s  = ADDR_W'(col_r);
        dbank_s = bank_r;
      end
      S_PRE: begin
        ras_n_s = 1'b0;
        we_n_s  = 1'b0;
        dbank_s = bank_r;
      end
      S_PREA: begin
        ras_n_s = 1'b0;
        we_n_s  = 1'b0;
        addr_s  = ADDR_A10;
      end
      S_REF: begin
        ras_n_s = 1'b0;
        cas_n_s = 1'b0;
      end
      default: ras_n_s = 1'b1;
    endcase
  end

  assign bus.fsm_ready = (state_r == S_IDLE);
  assign bus.cmd_done  = done_r;
  assign bus.row_hit   = row_hit_r;
  assign bus.dfi_cs_n  = 1'b0;
  assign bus.dfi_ras_n = ras_n_s;
  assign bus.dfi_cas_n = cas_n_s;
  assign bus.dfi_we_n  = we_n_s;
  assign bus.dfi_cke   = 1'b1;
  assign bus.dfi_addr  = addr_s;
  assign bus.dfi_bank  = dbank_s;
endmodule

// File: tb/tb_fsm_dfi_mb.sv
// Self-checking bench for fsm_dfi_mb: directed scenarios plus randomized traffic
// checked cycle by cycle against a per-bank open-row timeline model.
module tb_fsm_dfi_mb;
  localparam int ADDR_W = 14, BANK_W = 3, COL_W = 10;
  localparam int T_RCD = 4, T_CL = 4, T_RP = 4, T_RFC = 8;
  localparam logic [2:0] C_NOP = 3'd0, C_RD = 3'd1, C_WR = 3'd2, C_SCRUB = 3'd3, C_REF = 3'd4;
  localparam int K_NOP = 0, K_ACT = 1, K_RD = 2, K_WR = 3, K_PRE = 4, K_PREA = 5, K_REF = 6, K_BAD = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  bit m_open [8];
  int m_row  [8];
  int e_kind [32];
  int e_addr [32];
  int e_bank [32];

  fsm_dfi_mb_if #(.ADDR_W(ADDR_W), .BANK_W(BANK_W)) bus ();

  fsm_dfi_mb #(
    .ADDR_W(ADDR_W), .BANK_W(BANK_W), .COL_W(COL_W),
    .tRCD(T_RCD), .CL(T_CL), .tRP(T_RP), .tRFC(T_RFC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no summary, required finish");
    $fatal(1, "watchdog");
  end

  function automatic int decode_pins();
    if (bus.dfi_cs_n !== 1'b0 || bus.dfi_cke !== 1'b1) return K_BAD;
    case ({bus.dfi_ras_n, bus.dfi_cas_n, bus.dfi_we_n})
      3'b111:  return K_NOP;
      3'b011:  return K_ACT;
      3'b101:  return K_RD;
      3'b100:  return K_WR;
      3'b010:  return (bus.dfi_addr[10] === 1'b1) ? K_PREA : K_PRE;
      3'b001:  return K_REF;
      default: return K_BAD;
    endcase
  endfunction

  // Timeline model: which commands appear at which cycle after accept, and when done.
  task automatic model_plan(input logic [2:0] t, input int b, input int r, input int c,
                            output int done, output bit hit, output bit drop);
    int  n;
    bit  any;
    for (int i = 0; i < 32; i++) begin e_kind[i] = K_NOP; e_addr[i] = 0; e_bank[i] = 0; end
    drop = 1'b0; hit = 1'b0; done = 0; n = 1;
    if (t == C_RD || t == C_WR || t == C_SCRUB) begin
      if (m_open[b] && m_row[b] == r) begin
        hit = 1'b1;
      end else begin
        if (m_open[b]) begin
          e_kind[n] = K_PRE; e_addr[n] = 0; e_bank[n] = b; n += T_RP;
        end
        e_kind[n] = K_ACT; e_addr[n] = r; e_bank[n] = b; n += T_RCD;
        m_open[b] = 1'b1; m_row[b] = r;
      end
      e_kind[n] = (t == C_WR) ? K_WR : K_RD; e_addr[n] = c; e_bank[n] = b;
      done = n + T_CL;
    end else if (t == C_REF) begin
      any = 1'b0;
      for (int i = 0; i < 8; i++) any |= m_open[i];
      if (any) begin
        e_kind[n] = K_PREA; e_addr[n] = 1024; e_bank[n] = 0; n += T_RP;
        for (int i = 0; i < 8; i++) m_open[i] = 1'b0;
      end
      e_kind[n] = K_REF;
      done = n + T_RFC;
    end else begin
      drop = 1'b1;
    end
  endtask

  // Entered at a negedge with the FSM ready; returns at the negedge of the done cycle.
  task automatic run_cmd(input logic [2:0] t, input int b, input int r, input int c,
                         output int obs_done, output int first_kind);
    int          done, last, k;
    bit          hit, drop;
    logic        exp_d, exp_rdy;
    logic [31:0] a;
    model_plan(t, b, r, c, done, hit, drop);
    a = (32'(r) << (COL_W + BANK_W)) | (32'(b) << COL_W) | 32'(c);
    a[31:27] = 5'($urandom);
    n_tests++;
    if (bus.fsm_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_at_accept: got %b, required 1", bus.fsm_ready);
    end
    bus.cmd_valid = 1'b1; bus.cmd_type = t; bus.cmd_addr = a;
    obs_done = 0; first_kind = K_BAD;
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.cmd_type = 3'($urandom); bus.cmd_addr = $urandom;
    last = drop ? 3 : done;
    for (int cy = 1; cy <= last; cy++) begin
      k = decode_pins();
      if (cy == 1) first_kind = k;
      n_tests++;
      if (k !== e_kind[cy] || bus.dfi_addr !== ADDR_W'(e_addr[cy]) || bus.dfi_bank !== BANK_W'(e_bank[cy])) begin
        n_fail++;
        $display("FAIL pins type=%0d cycle %0d: got kind=%0d addr=%h bank=%0d, required kind=%0d addr=%h bank=%0d",
                 t, cy, k, bus.dfi_addr, bus.dfi_bank, e_kind[cy], e_addr[cy], e_bank[cy]);
      end
      exp_d = (!drop && cy == done);
      n_tests++;
      if (bus.cmd_done !== exp_d) begin
        n_fail++; $display("FAIL cmd_done cycle %0d: got %b, required %b", cy, bus.cmd_done, exp_d);
      end
      if (bus.cmd_done === 1'b1 && obs_done == 0) obs_done = cy;
      exp_rdy = (drop || cy == last);
      n_tests++;
      if (bus.fsm_ready !== exp_rdy) begin
        n_fail++; $display("FAIL fsm_ready cycle %0d: got %b, required %b", cy, bus.fsm_ready, exp_rdy);
      end
      if (!drop && cy == last) begin
        n_tests++;
        if (bus.row_hit !== hit) begin
          n_fail++; $display("FAIL row_hit: got %b, required %b", bus.row_hit, hit);
        end
      end
      if (cy < last) @(negedge clk);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_tests++;
    if (got !== want) begin
      n_fail++; $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) begin m_open[i] = 1'b0; m_row[i] = 0; end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.fsm_ready !== 1'b1 || bus.cmd_done !== 1'b0 || bus.row_hit !== 1'b0 ||
        decode_pins() !== K_NOP || bus.dfi_addr !== '0 || bus.dfi_bank !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got ready=%b done=%b hit=%b kind=%0d addr=%h bank=%0d, required 1 0 0 0 0 0",
               bus.fsm_ready, bus.cmd_done, bus.row_hit, decode_pins(), bus.dfi_addr, bus.dfi_bank);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_open_page();
    int od, fk;
    run_cmd(C_RD, 2, 5, 16, od, fk);
    check_int("closed_read_done_cycle", od, 9);
    check_int("closed_read_first_cmd", fk, K_ACT);
    run_cmd(C_WR, 2, 5, 32, od, fk);
    check_int("hit_write_done_cycle", od, 5);
    check_int("hit_write_first_cmd", fk, K_WR);
    run_cmd(C_RD, 2, 9, 16, od, fk);
    check_int("conflict_read_done_cycle", od, 13);
    check_int("conflict_read_first_cmd", fk, K_PRE);
  endtask

  task automatic test_refresh();
    int od, fk;
    run_cmd(C_RD, 4, 1, 3, od, fk);
    run_cmd(C_REF, 0, 0, 0, od, fk);
    check_int("prea_refresh_done_cycle", od, 13);
    check_int("prea_refresh_first_cmd", fk, K_PREA);
    run_cmd(C_RD, 4, 1, 3, od, fk);
    check_int("read_after_refresh_first_cmd", fk, K_ACT);
    run_cmd(C_REF, 0, 0, 0, od, fk);
    run_cmd(C_REF, 0, 0, 0, od, fk);
    check_int("closed_refresh_done_cycle", od, 9);
    check_int("closed_refresh_first_cmd", fk, K_REF);
    run_cmd(C_NOP, 3, 3, 3, od, fk);
    check_int("nop_no_done", od, 0);
    run_cmd(3'd7, 1, 1, 1, od, fk);
    check_int("undefined_no_done", od, 0);
  endtask

  task automatic test_reset_mid();
    int od, fk;
    run_cmd(C_RD, 6, 7, 5, od, fk);
    bus.cmd_valid = 1'b1; bus.cmd_type = C_RD;
    bus.cmd_addr = (32'd3 << (COL_W + BANK_W)) | (32'd6 << COL_W) | 32'd9;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (decode_pins() !== K_NOP || bus.fsm_ready !== 1'b1 || bus.cmd_done !== 1'b0 || bus.dfi_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_op: got kind=%0d ready=%b done=%b addr=%h, required 0 1 0 0",
               decode_pins(), bus.fsm_ready, bus.cmd_done, bus.dfi_addr);
    end
    for (int i = 0; i < 8; i++) m_open[i] = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.cmd_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_abandon_done: got %b, required 0", bus.cmd_done);
    end
    run_cmd(C_RD, 6, 3, 9, od, fk);
    check_int("reissue_after_reset_first_cmd", fk, K_ACT);
  endtask

  task automatic test_back_to_back_random();
    int       od, fk, sel;
    logic [2:0] t;
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 9: t = C_RD;
        3, 4:       t = C_WR;
        5:          t = C_SCRUB;
        6:          t = C_REF;
        7:          t = C_NOP;
        default:    t = 3'($urandom_range(5, 7));
      endcase
      run_cmd(t, $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 1023), od, fk);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_type  = 3'd0;
    bus.cmd_addr  = 32'd0;
    test_reset();
    test_open_page();
    test_refresh();
    test_reset_mid();
    test_back_to_back_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
